// File: rtl/pipelined_carry_adder.sv
// Pipelined ripple-of-groups adder: one GROUP-bit slice resolved per stage, valid/ready with global enable.
// Define PCA_OVERFLOW_EN to add the signed-overflow output ovf.
module pipelined_carry_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GROUP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PCA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned REM    = (GROUP == 0) ? 1 : (WIDTH % GROUP);
  localparam int unsigned STAGES = (GROUP == 0 || WIDTH < GROUP) ? 1 : (WIDTH / GROUP);

  if (GROUP == 0 || WIDTH == 0 || REM != 0) begin : g_bad_cfg
    $error("pipelined_carry_adder: WIDTH must be a positive multiple of GROUP");
  end

  // Registered stage state; stage STAGES-1 drives the outputs.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];

  // Inputs seen by each stage and its combinational results.
  logic [WIDTH-1:0] op_a    [STAGES];
  logic [WIDTH-1:0] op_b    [STAGES];
  logic [WIDTH-1:0] s_in    [STAGES];
  logic             c_in    [STAGES];
  logic             v_in    [STAGES];
  logic [GROUP:0]   slice_r [STAGES];
  logic [WIDTH-1:0] nxt_s   [STAGES];

`ifdef PCA_OVERFLOW_EN
  logic sa_q  [STAGES];
  logic sb_q  [STAGES];
  logic sa_in [STAGES];
  logic sb_in [STAGES];
  logic ovf_d;
  logic ovf_q;
`endif

  logic advance;

  assign advance   = enable && (!out_valid || out_ready);
  assign in_ready  = advance;
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
`ifdef PCA_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

  always_comb begin
    op_a[0] = a;
    op_b[0] = b;
    c_in[0] = cin;
    v_in[0] = in_valid;
    s_in[0] = '0;
`ifdef PCA_OVERFLOW_EN
    sa_in[0] = a[WIDTH-1];
    sb_in[0] = b[WIDTH-1];
`endif
    for (int unsigned k = 1; k < STAGES; k++) begin
      op_a[k] = a_q[k-1];
      op_b[k] = b_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
      s_in[k] = s_q[k-1];
`ifdef PCA_OVERFLOW_EN
      sa_in[k] = sa_q[k-1];
      sb_in[k] = sb_q[k-1];
`endif
    end
    // Each stage fills in its own slice on top of the lower slices already resolved.
    for (int unsigned k = 0; k < STAGES; k++) begin
      slice_r[k] = {1'b0, op_a[k][k*GROUP +: GROUP]}
                 + {1'b0, op_b[k][k*GROUP +: GROUP]}
                 + {{GROUP{1'b0}}, c_in[k]};
      nxt_s[k] = s_in[k];
      nxt_s[k][k*GROUP +: GROUP] = slice_r[k][GROUP-1:0];
    end
`ifdef PCA_OVERFLOW_EN
    ovf_d = (sa_in[STAGES-1] == sb_in[STAGES-1])
         && (nxt_s[STAGES-1][WIDTH-1] != sa_in[STAGES-1]);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        s_q[k] <= '0;
        a_q[k] <= '0;
        b_q[k] <= '0;
`ifdef PCA_OVERFLOW_EN
        sa_q[k] <= 1'b0;
        sb_q[k] <= 1'b0;
`endif
      end
`ifdef PCA_OVERFLOW_EN
      ovf_q <= 1'b0;
`endif
    end else if (advance) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= v_in[k];
        c_q[k] <= slice_r[k][GROUP];
        s_q[k] <= nxt_s[k];
        a_q[k] <= op_a[k];
        b_q[k] <= op_b[k];
`ifdef PCA_OVERFLOW_EN
        sa_q[k] <= sa_in[k];
        sb_q[k] <= sb_in[k];
`endif
      end
`ifdef PCA_OVERFLOW_EN
      ovf_q <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Scoreboard bench for pipelined_carry_adder (WIDTH=32, GROUP=8, latency 4).
module tb_pipelined_carry_adder;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned GROUP = 8;

  logic             clk = 1'b0;
  logic             rst, enable, in_valid, in_ready, cin;
  logic             out_valid, out_ready, cout;
  logic [WIDTH-1:0] a, b, sum;
`ifdef PCA_OVERFLOW_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pipelined_carry_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef PCA_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic ci);
    logic [WIDTH:0] t;
    exp_t r;
    t   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    r.s = t[WIDTH-1:0];
    r.c = t[WIDTH];
    r.v = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
    return r;
  endfunction

  // Scoreboard: push on accept, pop/compare on retire, both judged just before the edge.
  always @(negedge clk) begin
    logic exp_ready;
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      exp_ready = enable && (!out_valid || out_ready);
      checks++;
      if (in_ready !== exp_ready) begin
        errors++;
        $display("FAIL in_ready: got %b expected %b", in_ready, exp_ready);
      end
      if (in_valid && exp_ready) sb.push_back(model(a, b, cin));
      if (out_valid && out_ready && enable) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL retire_empty: got sum=%h with no beat expected", sum);
        end else begin
          e = sb.pop_front();
          if (sum !== e.s || cout !== e.c) begin
            errors++;
            $display("FAIL scoreboard: got sum=%h cout=%b expected sum=%h cout=%b",
                     sum, cout, e.s, e.c);
          end
`ifdef PCA_OVERFLOW_EN
          checks++;
          if (ovf !== e.v) begin
            errors++;
            $display("FAIL scoreboard_ovf: got %b expected %b", ovf, e.v);
          end
`endif
        end
      end
    end
  end

  task automatic send_one(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic c, output int lat);
    a = x; b = y; cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== 32'h0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b expected 0 0 0", out_valid, sum, cout);
    end
`ifdef PCA_OVERFLOW_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b expected 0", ovf);
    end
`endif
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    enable = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready_disabled: got %b expected 0", in_ready);
    end
    enable = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int lat;
    send_one(32'h0000_00FF, 32'h0000_0001, 1'b0, lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL single_latency: got %0d expected 4", lat);
    end
    checks++;
    if (sum !== 32'h0000_0100 || cout !== 1'b0) begin
      errors++;
      $display("FAIL single_sum: got %h/%b expected 00000100/0", sum, cout);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_carry_ripple();
    int lat;
    send_one(32'hFFFF_FFFF, 32'h0, 1'b1, lat);
    checks++;
    if (lat != 4 || sum !== 32'h0 || cout !== 1'b1) begin
      errors++;
      $display("FAIL carry_ripple: got lat=%0d sum=%h cout=%b expected 4 00000000 1", lat, sum, cout);
    end
`ifdef PCA_OVERFLOW_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL carry_ripple_ovf: got %b expected 0", ovf);
    end
`endif
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_overflow();
    int lat;
    send_one(32'h7FFF_FFFF, 32'h1, 1'b0, lat);
    checks++;
    if (lat != 4 || sum !== 32'h8000_0000 || cout !== 1'b0) begin
      errors++;
      $display("FAIL overflow_sum: got lat=%0d sum=%h cout=%b expected 4 80000000 0", lat, sum, cout);
    end
`ifdef PCA_OVERFLOW_EN
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow_ovf: got %b expected 1", ovf);
    end
`endif
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int e;
    logic exp_v;
    logic [WIDTH-1:0] exp_s;
    for (int t = 0; t < 23; t++) begin
      if (t < 16) begin
        in_valid = 1'b1; a = WIDTH'(t); b = WIDTH'(2 * t); cin = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      e = t + 1;
      exp_v = (e >= 4 && e <= 19);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL b2b_valid edge %0d: got %b expected %b", e, out_valid, exp_v);
      end else if (exp_v) begin
        exp_s = WIDTH'(3 * (e - 4));
        checks++;
        if (sum !== exp_s) begin
          errors++;
          $display("FAIL b2b_sum edge %0d: got %h expected %h", e, sum, exp_s);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    logic [WIDTH-1:0] hs;
    logic hc;
    for (int cyc = 0; cyc < 30; cyc++) begin
      in_valid  = (idx < 12);
      a         = $urandom;
      b         = $urandom;
      cin       = 1'($urandom_range(0, 1));
      out_ready = !(cyc >= 6 && cyc < 11);
      @(negedge clk);
      if (cyc == 6) begin
        hs = sum; hc = cout;
      end
      if (cyc >= 6 && cyc < 11) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== hs || cout !== hc) begin
          errors++;
          $display("FAIL backpressure_hold cyc %0d: got rdy=%b vld=%b sum=%h cout=%b expected 0 1 %h %b",
                   cyc, in_ready, out_valid, sum, cout, hs, hc);
        end
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (idx != 12 || sb.size() != 0) begin
      errors++;
      $display("FAIL backpressure_drain: got sent=%0d pending=%0d expected 12 0", idx, sb.size());
    end
  endtask

  task automatic test_enable();
    int idx = 0;
    logic [WIDTH-1:0] hs;
    logic hc, hv;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 26; cyc++) begin
      in_valid = (idx < 10);
      a        = $urandom;
      b        = $urandom;
      cin      = 1'($urandom_range(0, 1));
      enable   = !(cyc >= 6 && cyc < 9);
      @(negedge clk);
      if (cyc == 6) begin
        hs = sum; hc = cout; hv = out_valid;
      end
      if (cyc >= 6 && cyc < 9) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== hv || hv !== 1'b1 || sum !== hs || cout !== hc) begin
          errors++;
          $display("FAIL enable_freeze cyc %0d: got rdy=%b vld=%b sum=%h cout=%b expected 0 1 %h %b",
                   cyc, in_ready, out_valid, sum, cout, hs, hc);
        end
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; enable = 1'b1;
    checks++;
    if (idx != 10 || sb.size() != 0) begin
      errors++;
      $display("FAIL enable_drain: got sent=%0d pending=%0d expected 10 0", idx, sb.size());
    end
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = WIDTH'(100 + i); b = WIDTH'(7); cin = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_flush cycle %0d: got out_valid=%b sum=%h expected 0", i, out_valid, sum);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL reset_flush_pending: got %0d expected 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0;
    test_reset();
    test_single();
    test_carry_ripple();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_enable();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
